dram_responder: RTL and testbench

DRAM_RESPONDER -- requirements
Module: dram_responder

---
 rtl/dram_responder_pkg.sv | 46 ++++
 rtl/dram_rd_pipe.sv | 53 +++++
 rtl/dram_responder.sv | 121 ++++++++++++
 tb/tb_dram_responder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_responder_pkg.sv
// Shared DRAM model types: request/response packs, bus widths, default depth
// and the default read pattern returned for never-written words.

`ifndef DRAM_DEFINES_SVH
`define DRAM_DEFINES_SVH
`define DRAMA_DIM 16
`define DRAM_DIM 16
`endif

package dram_responder_pkg;

    // Address and data widths as seen by the CNN controller
    localparam int DRAMA_W = `DRAMA_DIM;
    localparam int DRAM_W  = `DRAM_DIM;

    // Default number of modelled words
    localparam int DRAM_MEM_DEPTH = 1024;

    // Default request-to-response read latency
    localparam int DRAM_RD_LAT = 2;

    // Request/statistic counter width and saturation value
    localparam int              DRAM_CNT_W   = 16;
    localparam logic [15:0]     DRAM_CNT_MAX = 16'hFFFF;

    // Request from the controller: word address, write data, write enable
    typedef struct packed {
        logic [DRAMA_W-1:0] Addr;
        logic [DRAM_W-1:0]  Data;
        logic               WEN;
    } DRAM_IN_PACK;

    // Read response towards the controller
    typedef struct packed {
        logic [DRAM_W-1:0] Data;
    } DRAM_OUT_PACK;

    // Pattern for a word that was never written: Addr+1 in address width
    // (so all-ones wraps to zero), then resized to the data width.
    function automatic logic [DRAM_W-1:0] default_pattern(input logic [DRAMA_W-1:0] addr);
        logic [DRAMA_W-1:0] next_addr;
        next_addr = addr + DRAMA_W'(1);
        return DRAM_W'(next_addr);
    endfunction

endpackage

// File: rtl/dram_rd_pipe.sv
// Fixed-latency valid/data delay line for read responses. Data travels as
// zero whenever its valid bit is clear, so the tail stage can drive the
// response bus directly without an extra output mask.

module dram_rd_pipe
    import dram_responder_pkg::*;
#(
    parameter int LAT = DRAM_RD_LAT,
    parameter int W   = DRAM_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    generate
        for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
            logic         valid_reg;
            logic [W-1:0] data_reg;

            if (gi == 0) begin : g_head
                // First stage captures the read result at the accepting edge
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        valid_reg <= 1'b0;
                        data_reg  <= '0;
                    end else begin
                        valid_reg <= in_valid;
                        data_reg  <= in_valid ? in_data : '0;
                    end
                end
            end else begin : g_body
                // Later stages simply shift the previous stage along
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        valid_reg <= 1'b0;
                        data_reg  <= '0;
                    end else begin
                        valid_reg <= g_stage[gi-1].valid_reg;
                        data_reg  <= g_stage[gi-1].data_reg;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[LAT-1].valid_reg;
    assign out_data  = g_stage[LAT-1].data_reg;

endmodule

// File: rtl/dram_responder.sv
// Behavioural DRAM responder for the CNN controller. Accepts one request per
// cycle with no backpressure, stores writes into a word array, and answers
// reads a fixed RD_LAT (1..4) cycles later in request order. Never-written
// words read back as Addr+1; out-of-range requests flag addr_err, writes are
// dropped and reads return zero.

module dram_responder
    import dram_responder_pkg::*;
#(
    parameter int MEM_DEPTH = DRAM_MEM_DEPTH,
    parameter int RD_LAT    = DRAM_RD_LAT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    input  DRAM_IN_PACK  DRAM_in,
    output DRAM_OUT_PACK DRAM_out,
    output logic         rsp_valid,
    output logic         addr_err,
    output logic [15:0]  rd_cnt,
    output logic [15:0]  wr_cnt
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // Word storage; contents are meaningless until the matching written bit is set
    logic [DRAM_W-1:0]    mem [MEM_DEPTH];
    logic [MEM_DEPTH-1:0] written_reg;

    logic                 in_range;
    logic [IDX_W-1:0]     idx;
    logic                 wr_fire;
    logic                 rd_fire;
    logic [DRAM_W-1:0]    rd_data;

    logic                 addr_err_reg;
    logic [15:0]          rd_cnt_reg;
    logic [15:0]          wr_cnt_reg;

    logic                 pipe_valid;
    logic [DRAM_W-1:0]    pipe_data;

    // Request decode: range check and which action fires this cycle
    always_comb begin
        in_range = 32'(DRAM_in.Addr) < 32'(MEM_DEPTH);
        idx      = DRAM_in.Addr[IDX_W-1:0];
        wr_fire  = req_valid &  DRAM_in.WEN & in_range;
        rd_fire  = req_valid & ~DRAM_in.WEN;
    end

    // Read result sampled at the accepting edge: stored word, default pattern or zero
    always_comb begin
        rd_data = '0;
        if (in_range) begin
            if (written_reg[idx]) begin
                rd_data = mem[idx];
            end else begin
                rd_data = default_pattern(DRAM_in.Addr);
            end
        end
    end

    // Word array write port; no reset, the written bits guard every read
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[idx] <= DRAM_in.Data;
        end
    end

    // Written bits mark which words hold real data; cleared by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            written_reg <= '0;
        end else if (wr_fire) begin
            written_reg[idx] <= 1'b1;
        end
    end

    // One-cycle error pulse for any request outside the modelled range
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_err_reg <= 1'b0;
        end else begin
            addr_err_reg <= req_valid & ~in_range;
        end
    end

    // Saturating counts of accepted in-range reads and writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_cnt_reg <= '0;
            wr_cnt_reg <= '0;
        end else begin
            if (rd_fire && in_range && (rd_cnt_reg != DRAM_CNT_MAX)) begin
                rd_cnt_reg <= rd_cnt_reg + 16'd1;
            end
            if (wr_fire && (wr_cnt_reg != DRAM_CNT_MAX)) begin
                wr_cnt_reg <= wr_cnt_reg + 16'd1;
            end
        end
    end

    dram_rd_pipe #(
        .LAT (RD_LAT),
        .W   (DRAM_W)
    ) u_rd_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_fire),
        .in_data   (rd_data),
        .out_valid (pipe_valid),
        .out_data  (pipe_data)
    );

    assign rsp_valid     = pipe_valid;
    assign DRAM_out.Data = pipe_data;
    assign addr_err      = addr_err_reg;
    assign rd_cnt        = rd_cnt_reg;
    assign wr_cnt        = wr_cnt_reg;

endmodule

// File: tb/tb_dram_responder.sv
// Self-checking bench for dram_responder: a queue-based reference model is
// compared against the DUT on every falling edge, and directed scenarios pin
// literal values for the documented corner cases. Random traffic follows.

module tb_dram_responder;
    import dram_responder_pkg::*;

    localparam int MEM_DEPTH = 1024;
    localparam int RD_LAT    = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    DRAM_IN_PACK  din = '0;
    DRAM_OUT_PACK dout;
    logic         rsp_valid;
    logic         addr_err;
    logic [15:0]  rd_cnt;
    logic [15:0]  wr_cnt;

    dram_responder #(
        .MEM_DEPTH (MEM_DEPTH),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .DRAM_in   (din),
        .DRAM_out  (dout),
        .rsp_valid (rsp_valid),
        .addr_err  (addr_err),
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt)
    );

    always #5 clk = ~clk;

    int test_cnt = 0;
    int fail_cnt = 0;
    bit verbose  = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        test_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        longint            due;
        logic [DRAM_W-1:0] data;
    } exp_t;

    exp_t              exp_q[$];
    logic [DRAM_W-1:0] m_mem [MEM_DEPTH];
    bit                m_written [MEM_DEPTH];
    int                m_rd = 0;
    int                m_wr = 0;
    bit                m_err = 1'b0;
    longint            edge_n = 0;
    int                m_a;
    exp_t              m_e;

    function automatic logic [DRAM_W-1:0] model_read(input int a);
        if (a >= MEM_DEPTH) return '0;
        if (m_written[a]) return m_mem[a];
        return DRAM_W'((a + 1) % (1 << DRAMA_W));
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            foreach (m_written[i]) m_written[i] = 1'b0;
            m_rd  = 0;
            m_wr  = 0;
            m_err = 1'b0;
        end else begin
            edge_n++;
            m_err = 1'b0;
            if (req_valid) begin
                m_a = int'(din.Addr);
                if (m_a >= MEM_DEPTH) m_err = 1'b1;
                if (din.WEN) begin
                    if (m_a < MEM_DEPTH) begin
                        m_mem[m_a]     = din.Data;
                        m_written[m_a] = 1'b1;
                        if (m_wr < 65535) m_wr++;
                    end
                end else begin
                    m_e.due  = edge_n + RD_LAT - 1;
                    m_e.data = model_read(m_a);
                    exp_q.push_back(m_e);
                    if (m_a < MEM_DEPTH && m_rd < 65535) m_rd++;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit                c_ev;
    logic [DRAM_W-1:0] c_ed;

    always @(negedge clk) begin
        c_ev = (exp_q.size() > 0) && (exp_q[0].due == edge_n);
        c_ed = c_ev ? exp_q[0].data : '0;
        if (c_ev) void'(exp_q.pop_front());
        chk("model_rsp_valid", 32'(rsp_valid), 32'(c_ev));
        chk("model_rsp_data", 32'(dout.Data), 32'(c_ed));
        chk("model_addr_err", 32'(addr_err), 32'(m_err));
        chk("model_rd_cnt", 32'(rd_cnt), 32'(m_rd));
        chk("model_wr_cnt", 32'(wr_cnt), 32'(m_wr));
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit v, input bit w, input logic [15:0] a, input logic [15:0] d);
        #1;
        req_valid = v;
        din.WEN   = w;
        din.Addr  = a;
        din.Data  = d;
        if (v && verbose) $display("[TB] req %s addr=0x%04h data=0x%04h", w ? "WR" : "RD", a, d);
    endtask

    // Idle cycle with garbage on the request bus, which must be ignored
    task automatic idle();
        drive(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    endtask

    // Returns just after the falling edge where reset was released
    task automatic pulse_reset();
        @(negedge clk);
        #1;
        reset     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    logic [15:0] r_addr;
    int          r_sel;

    initial begin
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_data", 32'(dout.Data), 32'd0);
        chk("reset_addr_err", 32'(addr_err), 32'd0);
        chk("reset_rd_cnt", 32'(rd_cnt), 32'd0);
        chk("reset_wr_cnt", 32'(wr_cnt), 32'd0);
        #1 reset = 1'b1;

        // Unwritten read: Addr 5 -> 6 at +2, issued on first edge after release
        pulse_reset();
        drive(1, 0, 16'h0005, 16'h0);
        @(negedge clk);
        chk("rd5_plus1_valid", 32'(rsp_valid), 32'd0);
        idle();
        @(negedge clk);
        chk("rd5_valid", 32'(rsp_valid), 32'd1);
        chk("rd5_data", 32'(dout.Data), 32'h6);
        chk("rd5_rd_cnt", 32'(rd_cnt), 32'd1);
        idle();
        @(negedge clk);
        chk("rd5_plus3_valid", 32'(rsp_valid), 32'd0);

        // Write then read back-to-back at the same address
        pulse_reset();
        drive(1, 1, 16'h0010, 16'hBEEF);
        @(negedge clk);
        drive(1, 0, 16'h0010, 16'h0);
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("wr_rd_valid", 32'(rsp_valid), 32'd1);
        chk("wr_rd_data", 32'(dout.Data), 32'hBEEF);
        chk("wr_rd_wr_cnt", 32'(wr_cnt), 32'd1);
        chk("wr_rd_rd_cnt", 32'(rd_cnt), 32'd1);

        // Out-of-range read, out-of-range write (must not alias), last in-range word
        pulse_reset();
        drive(1, 0, 16'h0400, 16'h0);
        @(negedge clk);
        chk("oor_err_pulse", 32'(addr_err), 32'd1);
        chk("oor_plus1_valid", 32'(rsp_valid), 32'd0);
        drive(1, 1, 16'h0400, 16'h1234);
        @(negedge clk);
        chk("oor_valid", 32'(rsp_valid), 32'd1);
        chk("oor_data", 32'(dout.Data), 32'd0);
        chk("oor_wr_err", 32'(addr_err), 32'd1);
        chk("oor_rd_cnt", 32'(rd_cnt), 32'd0);
        chk("oor_wr_cnt", 32'(wr_cnt), 32'd0);
        drive(1, 0, 16'h0000, 16'h0);
        @(negedge clk);
        chk("oor_err_clear", 32'(addr_err), 32'd0);
        drive(1, 0, 16'h03FF, 16'h0);
        @(negedge clk);
        chk("alias_data", 32'(dout.Data), 32'h1);
        idle();
        @(negedge clk);
        chk("last_word_data", 32'(dout.Data), 32'h0400);

        // Four back-to-back reads of 0..3
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            if (i >= 2) begin
                chk("burst_valid", 32'(rsp_valid), 32'd1);
                chk("burst_data", 32'(dout.Data), 32'(i - 1));
            end
            if (i < 4) drive(1, 0, 16'(i), 16'h0);
            else idle();
            @(negedge clk);
        end
        chk("burst_end_valid", 32'(rsp_valid), 32'd0);

        // Reset while a read is in flight: no response, written bits cleared
        pulse_reset();
        drive(1, 1, 16'h0010, 16'hAAAA);
        @(negedge clk);
        drive(1, 0, 16'h0010, 16'h0);
        @(negedge clk);
        #1;
        reset     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("inflight_drop_valid", 32'(rsp_valid), 32'd0);
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_reset_quiet", 32'(rsp_valid), 32'd0);
            idle();
        end
        @(negedge clk);
        drive(1, 0, 16'h0010, 16'h0);
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("post_reset_valid", 32'(rsp_valid), 32'd1);
        chk("post_reset_data", 32'(dout.Data), 32'h0011);

        // Write counter saturation
        pulse_reset();
        verbose = 1'b0;
        for (int i = 0; i < 65534; i++) begin
            drive(1, 1, 16'($urandom_range(0, MEM_DEPTH - 1)), 16'($urandom));
            @(negedge clk);
        end
        verbose = 1'b1;
        chk("sat_pre", 32'(wr_cnt), 32'hFFFE);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 16'(i), 16'($urandom));
            @(negedge clk);
            chk("sat_hold", 32'(wr_cnt), 32'hFFFF);
        end
        chk("sat_rd_cnt", 32'(rd_cnt), 32'd0);

        // Random traffic with occasional reset pulses
        pulse_reset();
        verbose = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                #1;
                reset     = 1'b0;
                req_valid = 1'b0;
                @(negedge clk);
                #1 reset = 1'b1;
            end
            r_sel = int'($urandom_range(0, 9));
            if (r_sel == 0)      r_addr = 16'($urandom_range(MEM_DEPTH, 65535));
            else if (r_sel == 1) r_addr = 16'($urandom_range(0, MEM_DEPTH - 1));
            else                 r_addr = 16'($urandom_range(0, 15));
            drive($urandom_range(0, 99) < 75, 1'($urandom_range(0, 1)), r_addr, 16'($urandom));
            @(negedge clk);
        end
        idle();
        repeat (RD_LAT + 2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
